// File: rtl/seq_divider_4_bit_pkg.sv
// Shared state encoding and counter sizing for the sequential restoring divider.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_N = 4;

   // Step counter must hold the value N itself.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_divider_4_bit_if.sv
// Start/operand request and result bundle of the sequential divider.
interface seq_divider_4_bit_if #(parameter int unsigned N = 4);

   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );

endinterface

// File: rtl/full_adder_1bit.sv
// Single-bit full adder, the building block of the arithmetic components set.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_divider_4_bit_div_trial_sub.sv
// Combinational W-bit trial subtractor a - b: ripple of full adders, b inverted, carry-in 1.
module div_trial_sub #(parameter int unsigned W = 5) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   logic [W:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_bit
      full_adder_1bit u_fa (
         .a    (a[i]),
         .b    (~b[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   // No carry out of the two's-complement add means a < b.
   assign borrow = ~carry[W];

endmodule

// File: rtl/seq_divider_4_bit.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
import seq_divider_pkg::*;

module seq_divider_4_bit #(parameter int unsigned N = DEFAULT_N) (
   input logic          clk,
   input logic          rst,
   seq_divider_4_bit_if.slave bus
);

   localparam int unsigned CW = cnt_width(N);

   state_t         state, state_n;
   logic [CW-1:0]  count, count_n;
   logic [N:0]     a, a_n;
   logic [N-1:0]   q, q_n;
   logic [N-1:0]   d, d_n;
   logic [N-1:0]   quo, quo_n;
   logic [N-1:0]   rem, rem_n;
   logic           dbz, dbz_n;

   logic [2*N:0]   aq_sh;
   logic [N:0]     trial;
   logic           borrow;
   logic [N:0]     a_step;
   logic [N-1:0]   q_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic           neg_q, neg_q_n;
   logic           neg_r, neg_r_n;
   logic [N-1:0]   dd_mag, dv_mag;

   assign dd_mag = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
   assign dv_mag = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
`endif

   // {A,Q} shifted left as one vector; A's MSB is always 0 between steps.
   assign aq_sh = {a, q} << 1;

   div_trial_sub #(.W(N + 1)) u_trial (
      .a      (aq_sh[2*N:N]),
      .b      ({1'b0, d}),
      .diff   (trial),
      .borrow (borrow)
   );

   assign a_step = borrow ? aq_sh[2*N:N] : trial;
   assign q_step = aq_sh[N-1:0] | {{(N-1){1'b0}}, ~borrow};

   always_comb begin
      state_n = state;
      count_n = count;
      a_n     = a;
      q_n     = q;
      d_n     = d;
      quo_n   = quo;
      rem_n   = rem;
      dbz_n   = dbz;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_n = neg_q;
      neg_r_n = neg_r;
`endif
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  state_n = DONE;
                  quo_n   = '1;
                  rem_n   = bus.dividend;
                  dbz_n   = 1'b1;
               end else begin
                  state_n = CALC;
                  a_n     = '0;
                  count_n = CW'(N);
                  dbz_n   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                  q_n     = dd_mag;
                  d_n     = dv_mag;
                  neg_q_n = bus.dividend[N-1] ^ bus.divisor[N-1];
                  neg_r_n = bus.dividend[N-1];
`else
                  q_n     = bus.dividend;
                  d_n     = bus.divisor;
`endif
               end
            end
         end
         CALC: begin
            a_n     = a_step;
            q_n     = q_step;
            count_n = count - CW'(1);
            if (count == CW'(1)) begin
               state_n = DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
               quo_n   = neg_q ? -q_step : q_step;
               rem_n   = neg_r ? -a_step[N-1:0] : a_step[N-1:0];
`else
               quo_n   = q_step;
               rem_n   = a_step[N-1:0];
`endif
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         a     <= '0;
         q     <= '0;
         d     <= '0;
         quo   <= '0;
         rem   <= '0;
         dbz   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`endif
      end else begin
         state <= state_n;
         count <= count_n;
         a     <= a_n;
         q     <= q_n;
         d     <= d_n;
         quo   <= quo_n;
         rem   <= rem_n;
         dbz   <= dbz_n;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q <= neg_q_n;
         neg_r <= neg_r_n;
`endif
      end
   end

   assign bus.quotient    = quo;
   assign bus.remainder   = rem;
   assign bus.div_by_zero = dbz;
   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_seq_divider_4_bit.sv
// Randomized self-checking bench for seq_divider_4_bit against an arithmetic reference.
// Honours SEQ_DIVIDER_SIGNED_EN in the reference model when the RTL is built signed.
module tb_seq_divider_4_bit;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seq_divider_4_bit_if #(.N(N)) bus ();

   seq_divider_4_bit #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void ref_div(input logic [N-1:0] dd, input logic [N-1:0] dv,
                                   output logic [N-1:0] q, output logic [N-1:0] r);
`ifdef SEQ_DIVIDER_SIGNED_EN
      int sdd, sdv;
      sdd = int'($signed(dd));
      sdv = int'($signed(dv));
      if (sdv == 0) begin
         q = '1;
         r = dd;
      end else begin
         q = N'(sdd / sdv);
         r = N'(sdd % sdv);
      end
`else
      if (dv == '0) begin
         q = '1;
         r = dd;
      end else begin
         q = dd / dv;
         r = dd % dv;
      end
`endif
   endfunction

   // Called at a negedge; start is raised for cycle 0 of this operation.
   // again: cycle in which a second start (14/7) is pulsed while busy, -1 for none.
   // rst_at: cycle in which rst is held high, -1 for none.
   task automatic do_op(input logic [N-1:0] dd, input logic [N-1:0] dv,
                        input int again, input int rst_at);
      logic [N-1:0] eq, er;
      logic [N-1:0] gq = '0;
      logic [N-1:0] gr = '0;
      logic         gz = 1'b0;
      int exp_lat, last;
      int done_cnt = 0;
      int done_cyc = -1;

      ref_div(dd, dv, eq, er);
      exp_lat = (dv == '0) ? 1 : N + 1;
      last    = (rst_at >= 0) ? N + 4 : exp_lat + 1;

      bus.start    = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;

      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
            gq = bus.quotient;
            gr = bus.remainder;
            gz = bus.div_by_zero;
         end
         if (rst_at >= 0 && c > rst_at) begin
            if (c == rst_at + 1) begin
               check("rst_quotient",  bus.quotient,    0);
               check("rst_remainder", bus.remainder,   0);
               check("rst_busy",      bus.busy,        0);
               check("rst_done",      bus.done,        0);
               check("rst_dbz",       bus.div_by_zero, 0);
            end
         end else if (c <= exp_lat) begin
            check("busy", bus.busy, 1);
         end else begin
            check("idle_after_done", bus.busy, 0);
            check("held_quotient",   bus.quotient, eq);
            check("held_remainder",  bus.remainder, er);
         end
         bus.start = (c == again);
         if (c == again) begin
            bus.dividend = N'(14);
            bus.divisor  = N'(7);
         end else begin
            bus.dividend = N'($urandom);
            bus.divisor  = N'($urandom);
         end
         rst = (c == rst_at);
      end
      bus.start = 1'b0;
      rst       = 1'b0;

      if (rst_at >= 0) begin
         check("no_done_after_rst", done_cnt, 0);
      end else begin
         check("done_count",  done_cnt, 1);
         check("latency",     done_cyc, exp_lat);
         check("quotient",    gq, eq);
         check("remainder",   gr, er);
         check("div_by_zero", gz, (dv == '0) ? 1 : 0);
      end
   endtask

   initial begin
      int again, rst_at;
      logic [N-1:0] dd, dv;

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge clk);
      check("reset_quotient",  bus.quotient,    0);
      check("reset_remainder", bus.remainder,   0);
      check("reset_busy",      bus.busy,        0);
      check("reset_done",      bus.done,        0);
      check("reset_dbz",       bus.div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      do_op(N'(13), N'(3),  -1, -1);
      do_op(N'(15), N'(1),  -1, -1);
      do_op(N'(2),  N'(7),  -1, -1);
      do_op(N'(15), N'(15), -1, -1);
      do_op(N'(7),  N'(0),  -1, -1);
      do_op(N'(6),  N'(2),  -1, -1);
      do_op(N'(9),  N'(2),   2, -1);
      do_op(N'(12), N'(5),  -1,  3);
      do_op(N'(12), N'(5),  -1, -1);
`ifdef SEQ_DIVIDER_SIGNED_EN
      do_op(N'(9),  N'(2),  -1, -1);
      do_op(N'(8),  N'(15), -1, -1);
`endif

      for (int unsigned i = 0; i < (1 << N); i++) begin
         for (int unsigned j = 0; j < (1 << N); j++) begin
            do_op(N'(i), N'(j), -1, -1);
         end
      end

      for (int k = 0; k < 60; k++) begin
         dd     = N'($urandom);
         dv     = N'($urandom);
         again  = -1;
         rst_at = -1;
         case ($urandom_range(0, 3))
            0: again  = $urandom_range(1, (dv == '0) ? 1 : N + 1);
            1: if (dv != '0) rst_at = $urandom_range(1, N);
            default: ;
         endcase
         do_op(dd, dv, again, rst_at);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
